ccm_sequencer: RTL and testbench
================================

CCM_SEQUENCER -- requirements
Module: ccm_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: unsigned pixel channel width.
REQ-002 SHALL have parameter COEF_WIDTH, default 9: signed coefficient width, two's complement.
REQ-003 SHALL have parameter COEF_FRAC, default 7: number of fractional bits in each coefficient.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-005 SHALL have these ports, clock and reset first:
- clk  in  1: clock.
- reset  in  1: async active-high reset.
- in_r, in_g, in_b  in  DATA_WIDTH each: input pixel.
- in_valid  in  1; in_ready  out  1: input handshake.
- out_r, out_g, out_b  out  DATA_WIDTH each: corrected pixel.
- out_valid  out  1; out_ready  in  1: output handshake.
- coef_we  in  1; coef_addr  in  4; coef_wdata  in  COEF_WIDTH: shadow coefficient write port.
- coef_commit  in  1: request to copy the shadow coefficient set to the active set.
- busy  out  1: high whenever state is not IDLE.

Function
REQ-006 SHALL compute out_c = sum over k of M[c][k] * in_k, for c and k in {R,G,B}, using one shared 3-term dot-product datapath time-multiplexed over the three rows.
REQ-007 SHALL use states IDLE, ROW0, ROW1, ROW2, OUT, with these transitions:
- IDLE to ROW0 on accept.
- ROW0 to ROW1 to ROW2 to OUT, one cycle each.
- OUT to IDLE when out_ready is high.
- OUT to ROW0 when out_ready and in_valid are both high (accept a new pixel).
REQ-008 SHALL drive in_ready = (state==IDLE) or (state==OUT and out_ready); a pixel is accepted when in_valid and in_ready are both high.
REQ-009 SHALL register the accepted pixel and hold it stable through ROW0 to ROW2.
REQ-010 SHALL compute row n in state ROWn; out_valid SHALL rise exactly 4 cycles after the accept edge.
REQ-011 SHALL sustain a throughput of one pixel per 4 cycles when out_ready is held high.
REQ-012 SHALL, while out_valid is high and out_ready is low, hold out_r, out_g, out_b and out_valid unchanged.
REQ-013 SHALL form each row result on a DATA_WIDTH+COEF_WIDTH+2 bit signed sum, rounded by adding 2^(COEF_FRAC-1) and then arithmetic-shifting right by COEF_FRAC.
REQ-014 SHALL store coefficients row-major at coef_addr 0 to 8 (addr = 3*row + col); writes to addresses 9 to 15 SHALL be ignored.
REQ-015 SHALL accept shadow writes in any state, one per cycle.
REQ-016 SHALL set a commit-pending flag on coef_commit.
REQ-017 SHALL copy shadow to active, and clear the pending flag, on the first edge where state==IDLE with the flag set, or where an accept occurs with the flag set.
REQ-018 SHALL compute a pixel accepted on that same edge with the new active set.
REQ-019 SHALL NOT change the active set while a pixel is between ROW0 and ROW2.
REQ-020 SHALL include the write in the copy when coef_we and the commit copy occur on the same edge.

Reset
REQ-021 SHALL, while reset is high, force the following:
- state = IDLE.
- out_valid = 0; out_r, out_g, out_b = 0; busy = 0.
- pending flag cleared.
REQ-022 SHALL drive in_ready = 1 in IDLE after reset.
REQ-023 SHALL reset both shadow and active sets to identity: diagonal = 2^COEF_FRAC, others = 0.
REQ-024 SHALL, on reset asserted mid-pixel, discard the in-flight pixel with no output produced.

Configuration
REQ-025 SHALL honour macro CCM_SEQUENCER_CLAMP_EN:
- Defined: rounded results below 0 SHALL saturate to 0, and results above 2^DATA_WIDTH-1 SHALL saturate to 2^DATA_WIDTH-1.
- Undefined: the output SHALL be the low DATA_WIDTH bits of the rounded result (wrap).

Structure
REQ-026 SHALL take the state encoding, NUM_COEFS=9 and the coefficient address constants from shared package ccm_pkg.
REQ-027 SHALL instantiate the shared 3-term dot-product module as its single sub-module, with A unsigned, B signed, A_DATA_WIDTH=DATA_WIDTH, B_DATA_WIDTH=COEF_WIDTH.

Verification (DATA_WIDTH=8, COEF_WIDTH=9, COEF_FRAC=7)
REQ-028 SHALL cover identity: after reset, pixel (10,20,30) accepted at cycle 0 -> out (10,20,30) with out_valid at cycle 4.
REQ-029 SHALL cover overflow: M[0] = (255,0,0), R=200 -> sum 51000 -> out_r = 255 with clamp, 142 without clamp.
REQ-030 SHALL cover negative result: M[1] = (0,-128,0), G=50 -> out_g = 0 with clamp, 206 without clamp.
REQ-031 SHALL cover backpressure: out_ready low for 3 cycles at OUT -> outputs stable and in_ready=0; then out_ready and in_valid high -> next pixel accepted on the same edge.
REQ-032 SHALL cover commit during ROW1: the current pixel uses the old set, the next pixel uses the new set.
REQ-033 SHALL cover reset in ROW2: out_valid stays 0, busy=0, in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/ccm_pkg.sv
// ccm_pkg: shared state encoding and coefficient map for the colour-correction sequencer.
`default_nettype none

package ccm_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ROW0 = 3'd1,
      S_ROW1 = 3'd2,
      S_ROW2 = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   localparam int NUM_COEFS = 9;

   // Row-major matrix layout: addr = 3*row + col.
   localparam logic [3:0] ADDR_RR = 4'd0;
   localparam logic [3:0] ADDR_RG = 4'd1;
   localparam logic [3:0] ADDR_RB = 4'd2;
   localparam logic [3:0] ADDR_GR = 4'd3;
   localparam logic [3:0] ADDR_GG = 4'd4;
   localparam logic [3:0] ADDR_GB = 4'd5;
   localparam logic [3:0] ADDR_BR = 4'd6;
   localparam logic [3:0] ADDR_BG = 4'd7;
   localparam logic [3:0] ADDR_BB = 4'd8;

   function automatic logic is_diag(input int idx);
      return (idx == int'(ADDR_RR)) || (idx == int'(ADDR_GG)) || (idx == int'(ADDR_BB));
   endfunction

endpackage

`default_nettype wire

// File: rtl/ccm_sequencer_dot3.sv
// ccm_sequencer_dot3: combinational 3-term dot product with per-operand signedness.
`default_nettype none

module ccm_sequencer_dot3 #(
   parameter int A_DATA_WIDTH = 8,
   parameter int B_DATA_WIDTH = 9,
   parameter int A_SIGNED     = 0,
   parameter int B_SIGNED     = 1
) (
   input  logic [2:0][A_DATA_WIDTH-1:0]               i_a,
   input  logic [2:0][B_DATA_WIDTH-1:0]               i_b,
   output logic signed [A_DATA_WIDTH+B_DATA_WIDTH+1:0] o_sum
);

   localparam int SW = A_DATA_WIDTH + B_DATA_WIDTH + 2;

   logic signed [A_DATA_WIDTH:0] w_ae [3];
   logic signed [B_DATA_WIDTH:0] w_be [3];
   logic signed [SW-1:0]         w_p  [3];

   genvar k;
   generate
      for (k = 0; k < 3; k++) begin : g_term
         // One extra bit per operand lets unsigned inputs ride a signed multiplier.
         if (A_SIGNED != 0) begin : g_a_signed
            assign w_ae[k] = {i_a[k][A_DATA_WIDTH-1], i_a[k]};
         end else begin : g_a_unsigned
            assign w_ae[k] = {1'b0, i_a[k]};
         end
         if (B_SIGNED != 0) begin : g_b_signed
            assign w_be[k] = {i_b[k][B_DATA_WIDTH-1], i_b[k]};
         end else begin : g_b_unsigned
            assign w_be[k] = {1'b0, i_b[k]};
         end
         assign w_p[k] = SW'(w_ae[k]) * SW'(w_be[k]);
      end
   endgenerate

   assign o_sum = w_p[0] + w_p[1] + w_p[2];

endmodule

`default_nettype wire

// File: rtl/ccm_sequencer.sv
// ccm_sequencer: 3x3 colour-correction matrix, one shared dot product over three row cycles.
// Optional macro CCM_SEQUENCER_CLAMP_EN saturates results to [0, 2^DATA_WIDTH-1]; otherwise they wrap.
`default_nettype none

module ccm_sequencer
   import ccm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int COEF_WIDTH = 9,
   parameter int COEF_FRAC  = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_r,
   input  logic [DATA_WIDTH-1:0] in_g,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_r,
   output logic [DATA_WIDTH-1:0] out_g,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  coef_we,
   input  logic [3:0]            coef_addr,
   input  logic [COEF_WIDTH-1:0] coef_wdata,
   input  logic                  coef_commit,
   output logic                  busy
);

   localparam int SW = DATA_WIDTH + COEF_WIDTH + 2;
   localparam logic signed [SW-1:0]         c_round = SW'(2 ** (COEF_FRAC - 1));
   localparam logic signed [COEF_WIDTH-1:0] c_one   = COEF_WIDTH'(2 ** COEF_FRAC);

   state_t r_state, w_next;
   logic   w_in_ready, w_accept, w_copy;
   logic   r_pending;

   logic [DATA_WIDTH-1:0] r_pix_r, r_pix_g, r_pix_b;
   logic [DATA_WIDTH-1:0] r_out_r, r_out_g, r_out_b;

   logic signed [COEF_WIDTH-1:0] r_shadow [NUM_COEFS];
   logic signed [COEF_WIDTH-1:0] r_active [NUM_COEFS];
   logic signed [COEF_WIDTH-1:0] w_shadow [NUM_COEFS];

   logic [3:0]                  w_base;
   logic [2:0][DATA_WIDTH-1:0]  w_a;
   logic [2:0][COEF_WIDTH-1:0]  w_b;
   logic signed [SW-1:0]        w_sum, w_rnd, w_shift;
   logic [DATA_WIDTH-1:0]       w_res;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_in_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && out_ready);
      w_accept   = in_valid && w_in_ready;
      w_next     = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_ROW0;
         S_ROW0: w_next = S_ROW1;
         S_ROW1: w_next = S_ROW2;
         S_ROW2: w_next = S_OUT;
         S_OUT: begin
            if (w_accept)      w_next = S_ROW0;
            else if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == S_OUT);
   assign busy      = (r_state != S_IDLE);
   assign out_r     = r_out_r;
   assign out_g     = r_out_g;
   assign out_b     = r_out_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pix_r <= '0;
         r_pix_g <= '0;
         r_pix_b <= '0;
      end else if (w_accept) begin
         r_pix_r <= in_r;
         r_pix_g <= in_g;
         r_pix_b <= in_b;
      end
   end

   always_comb begin
      w_base = ADDR_RR;
      case (r_state)
         S_ROW1:  w_base = ADDR_GR;
         S_ROW2:  w_base = ADDR_BR;
         default: w_base = ADDR_RR;
      endcase
      for (int k = 0; k < 3; k++) begin
         w_b[k] = r_active[w_base + 4'(k)];
      end
   end

   assign w_a = {r_pix_b, r_pix_g, r_pix_r};

   ccm_sequencer_dot3 #(
      .A_DATA_WIDTH (DATA_WIDTH),
      .B_DATA_WIDTH (COEF_WIDTH),
      .A_SIGNED     (0),
      .B_SIGNED     (1)
   ) u_dot3 (
      .i_a   (w_a),
      .i_b   (w_b),
      .o_sum (w_sum)
   );

   assign w_rnd   = w_sum + c_round;
   assign w_shift = w_rnd >>> COEF_FRAC;

   always_comb begin
      w_res = w_shift[DATA_WIDTH-1:0];
`ifdef CCM_SEQUENCER_CLAMP_EN
      if (w_shift[SW-1])
         w_res = '0;
      else if (w_shift[SW-2:DATA_WIDTH] != '0)
         w_res = '1;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_r <= '0;
         r_out_g <= '0;
         r_out_b <= '0;
      end else begin
         case (r_state)
            S_ROW0:  r_out_r <= w_res;
            S_ROW1:  r_out_g <= w_res;
            S_ROW2:  r_out_b <= w_res;
            default: ;
         endcase
      end
   end

   // The copy takes the merged shadow so a write on the copy edge is included.
   always_comb begin
      w_shadow = r_shadow;
      if (coef_we && (coef_addr <= ADDR_BB))
         w_shadow[coef_addr] = coef_wdata;
   end

   assign w_copy = r_pending && ((r_state == S_IDLE) || w_accept);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= 1'b0;
         for (int i = 0; i < NUM_COEFS; i++) begin
            r_shadow[i] <= is_diag(i) ? c_one : '0;
            r_active[i] <= is_diag(i) ? c_one : '0;
         end
      end else begin
         r_shadow <= w_shadow;
         if (w_copy)
            r_active <= w_shadow;
         if (coef_commit)
            r_pending <= 1'b1;
         else if (w_copy)
            r_pending <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ccm_sequencer.sv
// tb_ccm_sequencer: scoreboard bench for ccm_sequencer (8-bit pixels, 9-bit Q2.7 coefficients).
`default_nettype none

module tb_ccm_sequencer;

   localparam int DW = 8;
   localparam int CW = 9;
   localparam int CF = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_r, in_g, in_b;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_r, out_g, out_b;
   logic          out_valid;
   logic          out_ready;
   logic          coef_we;
   logic [3:0]    coef_addr;
   logic [CW-1:0] coef_wdata;
   logic          coef_commit;
   logic          busy;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   int          tb_shadow [9];
   int          tb_active [9];
   logic [23:0] sb [$];

   ccm_sequencer #(
      .DATA_WIDTH (DW),
      .COEF_WIDTH (CW),
      .COEF_FRAC  (CF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_r        (in_r),
      .in_g        (in_g),
      .in_b        (in_b),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_r       (out_r),
      .out_g       (out_g),
      .out_b       (out_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_wdata  (coef_wdata),
      .coef_commit (coef_commit),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic int model_ch(input int row, input int r, input int g, input int b);
      int s;
      s = tb_active[3*row] * r + tb_active[3*row+1] * g + tb_active[3*row+2] * b;
      s = (s + (1 << (CF - 1))) >>> CF;
`ifdef CCM_SEQUENCER_CLAMP_EN
      if (s < 0)        s = 0;
      else if (s > 255) s = 255;
`else
      s = s & 255;
`endif
      return s;
   endfunction

   function automatic logic [23:0] model(input int r, input int g, input int b);
      return {8'(model_ch(0, r, g, b)), 8'(model_ch(1, r, g, b)), 8'(model_ch(2, r, g, b))};
   endfunction

   task automatic set_identity();
      for (int i = 0; i < 9; i++) begin
         tb_shadow[i] = (i % 4 == 0) ? 128 : 0;
         tb_active[i] = tb_shadow[i];
      end
   endtask

   // Output side of the scoreboard: a transfer happens at the edge after a negedge with valid&ready.
   always @(negedge clk) begin
      logic [23:0] e;
      cyc = cyc + 1;
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("out_r", int'(out_r), int'(e[23:16]));
            chk("out_g", int'(out_g), int'(e[15:8]));
            chk("out_b", int'(out_b), int'(e[7:0]));
         end
      end
   end

   task automatic send(input int r, input int g, input int b, output int acc_cyc);
      bit ok = 1'b0;
      int n  = 0;
      in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
      in_valid = 1'b1;
      acc_cyc  = -1;
      do begin
         @(negedge clk);
         ok = in_ready;
         if (ok) begin
            acc_cyc = cyc;
            sb.push_back(model(r, g, b));
         end
         n++;
         @(posedge clk);
         #1;
      end while (!ok && n < 40);
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic wr_coef(input int addr, input int val);
      coef_we    = 1'b1;
      coef_addr  = 4'(addr);
      coef_wdata = CW'(val);
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      if (addr < 9) tb_shadow[addr] = val;
   endtask

   task automatic commit_idle();
      coef_commit = 1'b1;
      @(posedge clk);
      #1;
      coef_commit = 1'b0;
      @(posedge clk);
      #1;
      tb_active = tb_shadow;
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || sb.size() != 0) && n < 60);
      if (n >= 60) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc [4];
      int a0, hold_cyc, n;
      bit seen;
      int perm [9];

      reset = 1'b1;
      in_r = '0; in_g = '0; in_b = '0;
      in_valid = 1'b0; out_ready = 1'b1;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0;
      set_identity();

      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_r", int'(out_r), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // Identity pixel; the accept cycle is cycle 0, out_valid must appear in cycle 4.
      send(10, 20, 30, a0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("latency_valid", int'(out_valid), (i == 4) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      drain();

      for (int i = 0; i < 4; i++) send(i * 37 + 5, 255 - i * 29, i * 61, acc[i]);
      for (int i = 1; i < 4; i++) chk("throughput_gap", acc[i] - acc[i-1], 4);
      drain();

      wr_coef(0, 255);
      wr_coef(1, 0);
      wr_coef(2, 0);
      commit_idle();
      send(200, 7, 9, a0);
      drain();

      // Negative row, ignored high addresses, and a write landing on the copy edge.
      wr_coef(3, 0);
      wr_coef(4, -128);
      wr_coef(5, 0);
      wr_coef(9, -256);
      wr_coef(15, 77);
      coef_commit = 1'b1;
      @(posedge clk);
      #1;
      coef_commit = 1'b0;
      wr_coef(8, 64);
      tb_active = tb_shadow;
      send(1, 50, 100, a0);
      drain();

      // Backpressure at OUT.
      out_ready = 1'b0;
      send(60, 70, 80, a0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 10) begin
         @(negedge clk);
         seen = out_valid;
         n++;
      end
      chk("bp_reach_out", int'(seen), 1);
      hold_cyc = cyc;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_in_ready", int'(in_ready), 0);
         if (sb.size() > 0) begin
            chk("bp_hold_r", int'(out_r), int'(sb[0][23:16]));
            chk("bp_hold_b", int'(out_b), int'(sb[0][7:0]));
         end
         hold_cyc = cyc;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(90, 100, 110, a0);
      chk("bp_same_edge_accept", a0, hold_cyc + 1);
      drain();

      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      set_identity();

      // Commit while the current pixel sits in ROW1.
      perm = '{0, 128, 0, 0, 0, 128, 128, 0, 0};
      for (int i = 0; i < 9; i++) wr_coef(i, perm[i]);
      send(10, 20, 30, a0);
      @(posedge clk);
      #1;
      coef_commit = 1'b1;
      @(posedge clk);
      #1;
      coef_commit = 1'b0;
      tb_active = tb_shadow;
      send(40, 50, 60, a0);
      drain();

      // Reset while in ROW2 drops the pixel.
      send(33, 44, 55, a0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("row2_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", int'(out_valid), 0);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_in_ready", int'(in_ready), 1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("post_rst_no_output", int'(seen), 0);
      chk("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
